// File: rtl/ring_pkg.sv
// Shared sizes, FSM encodings and coefficient-column helper for the systolic ring sequencer.
// Combinational content only; no latency, no flow control.
package ring_pkg;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int IW = $clog2(N);
  localparam int AW = $clog2(N*N);

  typedef logic [N-1:0][W-1:0] lane_t;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DRAIN   = 2'd3;

  // (k-1-phase) mod N; N is a power of two so IW-bit wraparound is the modulo
  function automatic logic [IW-1:0] coef_col(input logic [IW-1:0] k, input logic [IW-1:0] phase);
    return k - IW'(1) - phase;
  endfunction
endpackage

// File: rtl/ring_sequencer_if.sv
// Host, PE-ring and result-stream signals of ring_sequencer; err exists only with SEQ_ERR_EN.
// slave = sequencer view, master = host/PE/consumer view.
interface ring_sequencer_if;
  import ring_pkg::*;

  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [W-1:0]  coef_wdata;
  logic          vec_we;
  logic [IW-1:0] vec_addr;
  logic [W-1:0]  vec_wdata;
  logic          start;
  logic          busy;
  logic          done;
  logic          pe_reset;
  lane_t         pe_x_init;
  lane_t         pe_a;
  lane_t         pe_y;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_data;
  logic [IW-1:0] res_index;
`ifdef SEQ_ERR_EN
  logic          err;
`endif

  modport slave (
    input  coef_we, coef_addr, coef_wdata, vec_we, vec_addr, vec_wdata, start, pe_y, res_ready,
    output busy, done, pe_reset, pe_x_init, pe_a, res_valid, res_data, res_index
`ifdef SEQ_ERR_EN
    , output err
`endif
  );

  modport master (
    output coef_we, coef_addr, coef_wdata, vec_we, vec_addr, vec_wdata, start, pe_y, res_ready,
    input  busy, done, pe_reset, pe_x_init, pe_a, res_valid, res_data, res_index
`ifdef SEQ_ERR_EN
    , input err
`endif
  );
endinterface

// File: rtl/ring_coef_bank.sv
// N*N coefficient registers with one write port and N combinational read ports selected by phase.
// Write lands at the next edge; reads have zero latency.
module ring_coef_bank
  import ring_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [W-1:0]  i_wdata,
  input  logic [IW-1:0] i_phase,
  output lane_t         o_rd
);
  logic [N*N-1:0][W-1:0] r_coef;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_coef <= '0;
    end else if (i_we) begin
      r_coef[i_addr] <= i_wdata;
    end
  end

  // row-major address {row, col} because N is a power of two
  always_comb begin
    o_rd = '0;
    for (int k = 0; k < N; k++) begin
      o_rd[k] = r_coef[{IW'(k), coef_col(IW'(k), i_phase)}];
    end
  end
endmodule

// File: rtl/ring_sequencer.sv
// Feeds x and per-phase coefficients to an N-PE MAC ring, captures y and streams it out valid/ready.
// First result N+2 cycles after start; DRAIN holds data/index while res_ready is low. SEQ_ERR_EN adds sticky err.
module ring_sequencer
  import ring_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  ring_sequencer_if.slave bus
);
  logic [1:0]    r_state;
  logic [IW-1:0] r_phase;
  logic [IW-1:0] r_idx;
  logic          r_done;
  lane_t         r_x;
  lane_t         r_result;
  lane_t         w_coef;
  logic          w_idle;
  logic          w_run;
  logic          w_drain;

  assign w_idle  = (r_state == S_IDLE);
  assign w_run   = (r_state == S_RUN);
  assign w_drain = (r_state == S_DRAIN);

  ring_coef_bank u_coef (
    .clk     (clk),
    .reset   (reset),
    .i_we    (bus.coef_we & w_idle),
    .i_addr  (bus.coef_addr),
    .i_wdata (bus.coef_wdata),
    .i_phase (r_phase),
    .o_rd    (w_coef)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_phase  <= '0;
      r_idx    <= '0;
      r_done   <= 1'b0;
      r_x      <= '0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_idle && bus.vec_we) begin
        r_x[bus.vec_addr] <= bus.vec_wdata;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_RUN;
            r_phase <= '0;
          end
        end
        S_RUN: begin
          r_phase <= r_phase + IW'(1);
          if (r_phase == IW'(N-1)) begin
            r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          r_result <= bus.pe_y;
          r_idx    <= '0;
          r_state  <= S_DRAIN;
        end
        default: begin
          if (bus.res_ready) begin
            if (r_idx == IW'(N-1)) begin
              r_idx   <= '0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end
      endcase
    end
  end

`ifdef SEQ_ERR_EN
  logic r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (!w_idle && (bus.start || bus.coef_we || bus.vec_we)) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`endif

  // PEs are held in reset except while the ring is actually accumulating
  assign bus.busy      = !w_idle;
  assign bus.done      = r_done;
  assign bus.pe_reset  = !w_run;
  assign bus.pe_x_init = r_x;
  assign bus.pe_a      = w_run ? w_coef : '0;
  assign bus.res_valid = w_drain;
  assign bus.res_data  = w_drain ? r_result[r_idx] : '0;
  assign bus.res_index = r_idx;
endmodule

// File: tb/tb_ring_sequencer.sv
// Directed bench for ring_sequencer with a behavioural PE ring and a queue-based result scoreboard.
module tb_ring_sequencer;
  import ring_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  ring_sequencer_if bus ();

  ring_sequencer dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural PE ring: ym shifts around the ring, sum accumulates a*x, y shows sum after N steps
  logic [W-1:0] pe_ym  [N];
  logic [W-1:0] pe_sum [N];
  int           pe_cnt = 0;

  always @(posedge clk) begin
    if (bus.pe_reset) begin
      for (int k = 0; k < N; k++) begin
        pe_ym[k]  <= bus.pe_x_init[k];
        pe_sum[k] <= '0;
      end
      pe_cnt <= 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        pe_ym[k]  <= bus.pe_y[(k+N-1)%N];
        pe_sum[k] <= pe_sum[k] + bus.pe_a[k] * bus.pe_y[(k+N-1)%N];
      end
      if (pe_cnt < N) pe_cnt <= pe_cnt + 1;
    end
  end

  always_comb begin
    bus.pe_y = '0;
    for (int k = 0; k < N; k++) begin
      bus.pe_y[k] = (pe_cnt == N) ? pe_sum[k] : pe_ym[k];
    end
  end

  logic [IW-1:0] exp_idx_q [$];
  logic [W-1:0]  exp_dat_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every accepted result is popped and compared
  always @(negedge clk) begin
    if (rst_n && bus.res_valid && bus.res_ready) begin
      if (exp_dat_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%0h required=none", bus.res_data);
      end else begin
        check("res_index", 32'(bus.res_index), 32'(exp_idx_q.pop_front()));
        check("res_data", 32'(bus.res_data), 32'(exp_dat_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [W-1:0] d0, d1, d2, d3);
    logic [W-1:0] d [N];
    d = '{d0, d1, d2, d3};
    for (int i = 0; i < N; i++) begin
      exp_idx_q.push_back(IW'(i));
      exp_dat_q.push_back(d[i]);
    end
  endtask

  task automatic load(input logic [W-1:0] a [N*N], input logic [W-1:0] x [N]);
    for (int i = 0; i < N*N; i++) begin
      bus.coef_we    = 1'b1;
      bus.coef_addr  = AW'(i);
      bus.coef_wdata = a[i];
      bus.vec_we     = (i < N);
      bus.vec_addr   = IW'(i % N);
      bus.vec_wdata  = x[i % N];
      tick();
    end
    bus.coef_we = 1'b0;
    bus.vec_we  = 1'b0;
  endtask

  task automatic run_pass(input bit stall, input bit inject, output int first_valid, output int done_cyc);
    bit stalled = 0;
    bit injected = 0;
    logic [W-1:0]  held_d;
    logic [IW-1:0] held_i;
    first_valid = -1;
    done_cyc = -1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (bus.done) begin
        done_cyc = c;
        break;
      end
      if (bus.res_valid && first_valid < 0) first_valid = c;
      if (stall && !stalled && bus.res_valid && bus.res_index == IW'(1)) begin
        stalled = 1;
        held_d = bus.res_data;
        held_i = bus.res_index;
        bus.res_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          c++;
          check("stall_valid", 32'(bus.res_valid), 32'd1);
          check("stall_data", 32'(bus.res_data), 32'(held_d));
          check("stall_index", 32'(bus.res_index), 32'(held_i));
        end
        bus.res_ready = 1'b1;
      end
      if (inject && !injected && bus.res_valid) begin
        injected = 1;
        bus.start      = 1'b1;
        bus.coef_we    = 1'b1;
        bus.coef_addr  = '0;
        bus.coef_wdata = 16'h0055;
      end
      tick();
      bus.start   = 1'b0;
      bus.coef_we = 1'b0;
    end
    if (done_cyc < 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=none required=done");
    end
  endtask

  initial begin
    logic [W-1:0] a_id  [N*N];
    logic [W-1:0] a_row [N*N];
    logic [W-1:0] a_big [N*N];
    logic [W-1:0] x_seq [N];
    logic [W-1:0] x_one [N];
    logic [W-1:0] x_big [N];
    int fv, dc;

    for (int i = 0; i < N*N; i++) begin
      a_id[i]  = (i / N == i % N) ? 16'd2 : 16'd0;
      a_row[i] = W'(i % N + 1);
      a_big[i] = 16'h0100;
    end
    x_seq = '{16'd1, 16'd2, 16'd3, 16'd4};
    x_one = '{16'd1, 16'd1, 16'd1, 16'd1};
    x_big = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};

    bus.coef_we = 0; bus.coef_addr = '0; bus.coef_wdata = '0;
    bus.vec_we = 0; bus.vec_addr = '0; bus.vec_wdata = '0;
    bus.start = 0; bus.res_ready = 1'b1;

    repeat (3) tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_pe_reset", 32'(bus.pe_reset), 32'd1);
    check("rst_pe_a", 32'(bus.pe_a[0] | bus.pe_a[1] | bus.pe_a[2] | bus.pe_a[3]), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_data", 32'(bus.res_data), 32'd0);
    check("rst_res_index", 32'(bus.res_index), 32'd0);
`ifdef SEQ_ERR_EN
    check("rst_err", 32'(bus.err), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    load(a_id, x_seq);
    push_exp(16'd2, 16'd4, 16'd6, 16'd8);
    run_pass(0, 0, fv, dc);
    check("first_valid_cycle", 32'(fv), 32'd6);
    check("done_cycle", 32'(dc), 32'd10);
    tick();
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("idle_after_done", 32'(bus.busy), 32'd0);

    load(a_row, x_one);
    push_exp(16'd10, 16'd10, 16'd10, 16'd10);
    run_pass(0, 0, fv, dc);

    load(a_big, x_big);
    push_exp(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    run_pass(0, 0, fv, dc);

    load(a_id, x_seq);
    push_exp(16'd2, 16'd4, 16'd6, 16'd8);
    run_pass(1, 0, fv, dc);
    check("stall_done_cycle", 32'(dc), 32'd13);

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("run_pe_reset", 32'(bus.pe_reset), 32'd0);
    rst_n = 1'b0;
    tick();
    check("midrst_pe_reset", 32'(bus.pe_reset), 32'd1);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_res_valid", 32'(bus.res_valid), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    tick();
    load(a_row, x_seq);
    push_exp(16'd30, 16'd30, 16'd30, 16'd30);
    run_pass(0, 0, fv, dc);

    load(a_id, x_seq);
    push_exp(16'd2, 16'd4, 16'd6, 16'd8);
    run_pass(0, 1, fv, dc);
    check("inject_done_cycle", 32'(dc), 32'd10);
    tick();
    check("inject_no_restart", 32'(bus.busy), 32'd0);
`ifdef SEQ_ERR_EN
    check("err_set", 32'(bus.err), 32'd1);
`endif
    push_exp(16'd2, 16'd4, 16'd6, 16'd8);
    run_pass(0, 0, fv, dc);
`ifdef SEQ_ERR_EN
    check("err_sticky", 32'(bus.err), 32'd1);
`endif

    repeat (2) tick();
    check("scoreboard_empty", 32'(exp_dat_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
